// File: rtl/reg_file_2r1w_pkg.sv
// Shared sizing constants for the 2-read / 1-write register file.
package reg_file_2r1w_pkg;

    localparam int unsigned REG_COUNT      = 32;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = $clog2(REG_COUNT);
    localparam int unsigned ZERO_REG       = 0;

endpackage : reg_file_2r1w_pkg

// File: rtl/reg32_ld.sv
// Register with load enable and asynchronous active-low clear.
module reg32_ld
    import reg_file_2r1w_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Load new data when enabled, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (ld) begin
            data_d = d;
        end
    end

    // Storage flop, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : reg32_ld

// File: rtl/reg_file_2r1w.sv
// 32 x 32 register file, two registered read ports, one write port.
// Entry 0 is constant zero; optional write-to-read forwarding.
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  RD_VALID
);

    localparam int unsigned           DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [DEPTH-1:1]      we_dec;
    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DATA_WIDTH-1:0] rd1_sel;
    logic [DATA_WIDTH-1:0] rd2_sel;
    logic                  rd_valid_d;
    logic                  rd_valid_q;

    // One-hot write enable; address 0 has no storage so writes there vanish.
    always_comb begin
        we_dec = '0;
        if (WRITE) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (ADDR_W == ADDR_WIDTH'(i)) begin
                    we_dec[i] = 1'b1;
                end
            end
        end
    end

    assign regs[0] = '0;

    for (genvar g = 1; g < DEPTH; g++) begin : g_entry
        reg32_ld #(
            .WIDTH (DATA_WIDTH)
        ) u_entry (
            .clk   (CLK),
            .rst_n (RST),
            .ld    (we_dec[g]),
            .d     (DATA_W),
            .q     (regs[g])
        );
    end

    // Port 1 select: zero register, then forwarded write, then stored entry.
    always_comb begin
        rd1_sel = regs[ADDR_R1];
        if (ADDR_R1 == ZERO_ADDR) begin
            rd1_sel = '0;
        end else if (BYPASS && WRITE && (ADDR_W == ADDR_R1)) begin
            rd1_sel = DATA_W;
        end
    end

    // Port 2 select: same priority as port 1.
    always_comb begin
        rd2_sel = regs[ADDR_R2];
        if (ADDR_R2 == ZERO_ADDR) begin
            rd2_sel = '0;
        end else if (BYPASS && WRITE && (ADDR_W == ADDR_R2)) begin
            rd2_sel = DATA_W;
        end
    end

    reg32_ld #(
        .WIDTH (DATA_WIDTH)
    ) u_rd1 (
        .clk   (CLK),
        .rst_n (RST),
        .ld    (READ),
        .d     (rd1_sel),
        .q     (DATA_R1)
    );

    reg32_ld #(
        .WIDTH (DATA_WIDTH)
    ) u_rd2 (
        .clk   (CLK),
        .rst_n (RST),
        .ld    (READ),
        .d     (rd2_sel),
        .q     (DATA_R2)
    );

    // Valid follows the read strobe by one cycle.
    always_comb begin
        rd_valid_d = READ;
    end

    // Valid flop, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
        end
    end

    assign RD_VALID = rd_valid_q;

endmodule : reg_file_2r1w

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench: BYPASS=1 and BYPASS=0 instances share stimulus;
// a reference model predicts each read and a queue carries it to the check.
module tb_reg_file_2r1w;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        rd    = 1'b0;
    logic        wr    = 1'b0;
    logic [4:0]  ar1   = '0;
    logic [4:0]  ar2   = '0;
    logic [4:0]  aw    = '0;
    logic [31:0] dw    = '0;

    logic [31:0] r1_b, r2_b, r1_n, r2_n;
    logic        v_b, v_n;

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [32];
    logic [31:0] last_b1, last_b2, last_n1, last_n2;

    typedef struct {
        logic [31:0] r1b;
        logic [31:0] r2b;
        logic [31:0] r1n;
        logic [31:0] r2n;
    } exp_t;

    exp_t sb [$];

    typedef struct {
        logic        r;
        logic        w;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  aw;
        logic [31:0] d;
        logic        ev;
        logic [31:0] e1b;
        logic [31:0] e2b;
        logic [31:0] e1n;
        logic [31:0] e2n;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    reg_file_2r1w #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .BYPASS     (1'b1)
    ) dut_b (
        .CLK      (clk),
        .RST      (rst_n),
        .READ     (rd),
        .WRITE    (wr),
        .ADDR_R1  (ar1),
        .ADDR_R2  (ar2),
        .ADDR_W   (aw),
        .DATA_W   (dw),
        .DATA_R1  (r1_b),
        .DATA_R2  (r2_b),
        .RD_VALID (v_b)
    );

    reg_file_2r1w #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .BYPASS     (1'b0)
    ) dut_n (
        .CLK      (clk),
        .RST      (rst_n),
        .READ     (rd),
        .WRITE    (wr),
        .ADDR_R1  (ar1),
        .ADDR_R2  (ar2),
        .ADDR_W   (aw),
        .DATA_W   (dw),
        .DATA_R1  (r1_n),
        .DATA_R2  (r2_n),
        .RD_VALID (v_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] val(input logic [4:0] a, input bit byp,
                                        input logic w, input logic [4:0] wa,
                                        input logic [31:0] d);
        if (a == 5'd0) return 32'h0;
        if (byp && w && (wa == a)) return d;
        return mdl[a];
    endfunction

    // One clock of stimulus; predicts, then checks after the edge.
    task automatic step(input logic r, input logic w, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] wa, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        rd = r; wr = w; ar1 = a1; ar2 = a2; aw = wa; dw = d;
        if (r) begin
            e.r1b = val(a1, 1'b1, w, wa, d);
            e.r2b = val(a2, 1'b1, w, wa, d);
            e.r1n = val(a1, 1'b0, w, wa, d);
            e.r2n = val(a2, 1'b0, w, wa, d);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (w && (wa != 5'd0)) mdl[wa] = d;
        chk("rd_valid_byp", {31'b0, v_b}, {31'b0, r});
        chk("rd_valid_nobyp", {31'b0, v_n}, {31'b0, r});
        if (r) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                e = sb.pop_front();
                last_b1 = e.r1b; last_b2 = e.r2b;
                last_n1 = e.r1n; last_n2 = e.r2n;
            end
        end
        chk("data_r1_byp", r1_b, last_b1);
        chk("data_r2_byp", r2_b, last_b2);
        chk("data_r1_nobyp", r1_n, last_n1);
        chk("data_r2_nobyp", r2_n, last_n2);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        last_b1 = '0; last_b2 = '0; last_n1 = '0; last_n2 = '0;

        // Reset state, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("reset_valid", {31'b0, v_b}, 32'h0);
        chk("reset_r1", r1_b, 32'h0);
        chk("reset_r2_nobyp", r2_n, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read every register, ports walking in opposite directions.
        for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 5'd0, 5'd0, 5'(i), 32'h1000_0000 + i);
        for (int i = 1; i < 32; i++) step(1'b1, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);

        // Zero-register and collision vectors with literal expectations.
        tbl[0] = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h1111_1111, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 32'h2222_2222, 1'b1,
                   32'h2222_2222, 32'h2222_2222, 32'h1111_1111, 32'h1111_1111};
        tbl[4] = '{1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0, 1'b1,
                   32'h2222_2222, 32'h0, 32'h2222_2222, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 5'd7, 5'd8, 5'd8, 32'h3333_3333, 1'b1,
                   32'h2222_2222, 32'h3333_3333, 32'h2222_2222, 32'h1000_0008};
        tbl[6] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0,
                   32'h2222_2222, 32'h3333_3333, 32'h2222_2222, 32'h1000_0008};
        for (int k = 0; k < 7; k++) begin
            step(tbl[k].r, tbl[k].w, tbl[k].a1, tbl[k].a2, tbl[k].aw, tbl[k].d);
            chk("tbl_valid", {31'b0, v_n}, {31'b0, tbl[k].ev});
            chk("tbl_r1_byp", r1_b, tbl[k].e1b);
            chk("tbl_r2_byp", r2_b, tbl[k].e2b);
            chk("tbl_r1_nobyp", r1_n, tbl[k].e1n);
            chk("tbl_r2_nobyp", r2_n, tbl[k].e2n);
        end

        // Hold: outputs keep the last read while writes continue underneath.
        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'hA5A5_A5A5);
        step(1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 5'd9, 5'd9, 5'd3, 32'h5A5A_5A5A);
            chk("hold_r1", r1_b, 32'hA5A5_A5A5);
            chk("hold_valid", {31'b0, v_b}, 32'h0);
        end
        step(1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0);
        chk("hold_after_r1", r1_n, 32'h5A5A_5A5A);

        // Back-to-back reads.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 5'(i), 5'(9 - i), 5'd0, 32'h0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);

        // Unknown address/data with both strobes low must not disturb state.
        step(1'b0, 1'b0, 5'bx, 5'bx, 5'bx, 32'hx);
        step(1'b1, 1'b0, 5'd5, 5'd31, 5'd0, 32'h0);

        // Asynchronous reset in the middle of a cycle.
        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, v_b}, 32'h0);
        chk("async_rst_r1", r1_b, 32'h0);
        chk("async_rst_r2", r2_b, 32'h0);
        chk("async_rst_r1_nobyp", r1_n, 32'h0);
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        last_b1 = '0; last_b2 = '0; last_n1 = '0; last_n2 = '0;
        sb.delete();
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0);
        chk("post_rst_r5", r1_b, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_file_2r1w
